// File: rtl/game_round_pkg.sv
// Shared state encoding and constants for the game round controller.
// The OVER state exists only when GAME_ROUND_FSM_LIVES_EN is defined.
package game_round_pkg;

  typedef enum logic [2:0] {
    INIT,
    START,
    AIM,
    SHOOT,
    WON,
    LOST
`ifdef GAME_ROUND_FSM_LIVES_EN
    , OVER
`endif
  } state_t;

  // Sliced down to the instance's score width to give its saturation value.
  localparam logic [31:0] SCORE_SAT_ALL = '1;
  localparam logic [1:0]  LIVES_RESET   = 2'd3;

endpackage

// File: rtl/game_timeout_counter.sv
// End-of-round pause timer: loads all-ones, counts down once per enabled cycle,
// and flags expired while it sits at zero.
module game_timeout_counter #(
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic load,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] ONE = 1;

  logic [TIMEOUT_WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (enable) begin
      if (load)
        r_count <= '1;
      else if (r_count != '0)
        r_count <= r_count - ONE;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/game_round_fsm.sv
// Round controller driving the target and torpedo sprites: start, aim, shoot, win/lose, timed pause, score.
// Define GAME_ROUND_FSM_LIVES_EN for a three-life budget, a terminal OVER state and the game_over output.
module game_round_fsm
  import game_round_pkg::*;
#(
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int DX_WIDTH      = 2,
  parameter int DY_WIDTH      = 2,
  parameter int TARGET_X      = 0,
  parameter int TARGET_Y      = screen_height / 10,
  parameter int TARGET_DX     = 1,
  parameter int TARGET_DY     = 0,
  parameter int TORPEDO_X     = screen_width / 2,
  parameter int TORPEDO_Y     = screen_height - 16,
  parameter int TORPEDO_DX    = 0,
  parameter int TORPEDO_DY    = 3,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int SCORE_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   launch,
  input  logic                   collision,
  input  logic                   target_hit_wall,
  input  logic                   torpedo_hit_wall,
  output logic                   target_write_xy,
  output logic                   target_write_dxy,
  output logic [w_x-1:0]         target_write_x,
  output logic [w_y-1:0]         target_write_y,
  output logic [DX_WIDTH-1:0]    target_write_dx,
  output logic [DY_WIDTH-1:0]    target_write_dy,
  output logic                   target_enable_update,
  output logic                   torpedo_write_xy,
  output logic                   torpedo_write_dxy,
  output logic [w_x-1:0]         torpedo_write_x,
  output logic [w_y-1:0]         torpedo_write_y,
  output logic [DX_WIDTH-1:0]    torpedo_write_dx,
  output logic [DY_WIDTH-1:0]    torpedo_write_dy,
  output logic                   torpedo_enable_update,
  output logic                   end_of_game,
  output logic                   game_won,
`ifdef GAME_ROUND_FSM_LIVES_EN
  output logic                   game_over,
`endif
  output logic [SCORE_WIDTH-1:0] score
);

  localparam logic [SCORE_WIDTH-1:0] SCORE_SAT = SCORE_SAT_ALL[SCORE_WIDTH-1:0];
  localparam logic [SCORE_WIDTH-1:0] SCORE_ONE = 1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_load;
  logic                   w_expired;
  logic [SCORE_WIDTH-1:0] r_score;
`ifdef GAME_ROUND_FSM_LIVES_EN
  logic [1:0]             r_lives;
`endif

  game_timeout_counter #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .load    (w_load),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= INIT;
    else
      r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT:  w_next_state = START;
      START: w_next_state = AIM;
      AIM: begin
        if (target_hit_wall)
          w_next_state = LOST;
        else if (launch)
          w_next_state = SHOOT;
      end
      SHOOT: begin
        if (collision)
          w_next_state = WON;
        else if (target_hit_wall || torpedo_hit_wall)
          w_next_state = LOST;
      end
      WON, LOST: begin
        if (w_expired) begin
`ifdef GAME_ROUND_FSM_LIVES_EN
          w_next_state = (r_lives == 2'd0) ? OVER : START;
`else
          w_next_state = START;
`endif
        end
      end
      default: w_next_state = r_state;
    endcase
    if (!enable)
      w_next_state = r_state;
  end

  // The pause timer is armed only on the edge that enters WON or LOST.
  assign w_load = ((r_state == AIM) || (r_state == SHOOT)) &&
                  ((w_next_state == WON) || (w_next_state == LOST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_score <= '0;
    else if (enable && (r_state == SHOOT) && collision && (r_score != SCORE_SAT))
      r_score <= r_score + SCORE_ONE;
  end

`ifdef GAME_ROUND_FSM_LIVES_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_lives <= LIVES_RESET;
    else if (w_load && (w_next_state == LOST) && (r_lives != 2'd0))
      r_lives <= r_lives - 2'd1;
  end
`endif

  always_comb begin
    target_write_xy       = 1'b0;
    target_write_dxy      = 1'b0;
    target_enable_update  = 1'b0;
    torpedo_write_xy      = 1'b0;
    torpedo_write_dxy     = 1'b0;
    torpedo_enable_update = 1'b0;
    end_of_game           = 1'b0;
    game_won              = 1'b0;
`ifdef GAME_ROUND_FSM_LIVES_EN
    game_over             = 1'b0;
`endif
    case (r_state)
      START: begin
        target_write_xy   = 1'b1;
        target_write_dxy  = 1'b1;
        torpedo_write_xy  = 1'b1;
        torpedo_write_dxy = 1'b1;
      end
      AIM:   target_enable_update = 1'b1;
      SHOOT: begin
        target_enable_update  = 1'b1;
        torpedo_enable_update = 1'b1;
      end
      WON: begin
        end_of_game = 1'b1;
        game_won    = 1'b1;
      end
      LOST:  end_of_game = 1'b1;
`ifdef GAME_ROUND_FSM_LIVES_EN
      OVER: begin
        end_of_game = 1'b1;
        game_over   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign target_write_x   = TARGET_X[w_x-1:0];
  assign target_write_y   = TARGET_Y[w_y-1:0];
  assign target_write_dx  = TARGET_DX[DX_WIDTH-1:0];
  assign target_write_dy  = TARGET_DY[DY_WIDTH-1:0];
  assign torpedo_write_x  = TORPEDO_X[w_x-1:0];
  assign torpedo_write_y  = TORPEDO_Y[w_y-1:0];
  assign torpedo_write_dx = TORPEDO_DX[DX_WIDTH-1:0];
  assign torpedo_write_dy = TORPEDO_DY[DY_WIDTH-1:0];
  assign score            = r_score;

endmodule

// File: tb/tb_game_round_fsm.sv
// Directed bench for game_round_fsm with a 16-cycle pause and a 2-bit score.
// Lives scenarios run only when GAME_ROUND_FSM_LIVES_EN is defined.
module tb_game_round_fsm;

  localparam int S_INIT  = 0;
  localparam int S_START = 1;
  localparam int S_AIM   = 2;
  localparam int S_SHOOT = 3;
  localparam int S_WON   = 4;
  localparam int S_LOST  = 5;
  localparam int S_OVER  = 6;
  localparam int S_BAD   = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       launch = 1'b0;
  logic       collision = 1'b0;
  logic       target_hit_wall = 1'b0;
  logic       torpedo_hit_wall = 1'b0;
  logic       target_write_xy, target_write_dxy, target_enable_update;
  logic       torpedo_write_xy, torpedo_write_dxy, torpedo_enable_update;
  logic [9:0] target_write_x, torpedo_write_x;
  logic [8:0] target_write_y, torpedo_write_y;
  logic [1:0] target_write_dx, target_write_dy, torpedo_write_dx, torpedo_write_dy;
  logic       end_of_game, game_won;
  logic       game_over_w;
  logic [1:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_round_fsm #(
    .TIMEOUT_WIDTH (4),
    .SCORE_WIDTH   (2)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .launch                (launch),
    .collision             (collision),
    .target_hit_wall       (target_hit_wall),
    .torpedo_hit_wall      (torpedo_hit_wall),
    .target_write_xy       (target_write_xy),
    .target_write_dxy      (target_write_dxy),
    .target_write_x        (target_write_x),
    .target_write_y        (target_write_y),
    .target_write_dx       (target_write_dx),
    .target_write_dy       (target_write_dy),
    .target_enable_update  (target_enable_update),
    .torpedo_write_xy      (torpedo_write_xy),
    .torpedo_write_dxy     (torpedo_write_dxy),
    .torpedo_write_x       (torpedo_write_x),
    .torpedo_write_y       (torpedo_write_y),
    .torpedo_write_dx      (torpedo_write_dx),
    .torpedo_write_dy      (torpedo_write_dy),
    .torpedo_enable_update (torpedo_enable_update),
    .end_of_game           (end_of_game),
    .game_won              (game_won),
`ifdef GAME_ROUND_FSM_LIVES_EN
    .game_over             (game_over_w),
`endif
    .score                 (score)
  );

`ifndef GAME_ROUND_FSM_LIVES_EN
  assign game_over_w = 1'b0;
`endif

  // Classifies the Moore output pattern into the round phase it represents.
  function automatic int obs_state();
    logic [3:0] strobes;
    logic [1:0] ens;
    strobes = {target_write_xy, target_write_dxy, torpedo_write_xy, torpedo_write_dxy};
    ens     = {target_enable_update, torpedo_enable_update};
    if (strobes == 4'b1111 && ens == 2'b00 && !end_of_game) return S_START;
    if (strobes != 4'b0000) return S_BAD;
    if (!end_of_game) begin
      if (game_won || game_over_w) return S_BAD;
      if (ens == 2'b00) return S_INIT;
      if (ens == 2'b10) return S_AIM;
      if (ens == 2'b11) return S_SHOOT;
      return S_BAD;
    end
    if (ens != 2'b00) return S_BAD;
    if (game_over_w) return game_won ? S_BAD : S_OVER;
    return game_won ? S_WON : S_LOST;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps through a pause and checks how many cycles it takes to reach the exit state.
  task automatic wait_pause(input int exp_cycles, input int exit_state, input string name);
    int cycles;
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (obs_state() == exit_state) begin
        cycles = i;
        break;
      end
    end
    n_cmp++;
    if (cycles !== exp_cycles) begin
      n_bad++;
      $display("FAIL %s: pause took %0d cycles, expected %0d", name, cycles, exp_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    step();
    step();
    n_cmp++;
    if ({target_write_xy, target_write_dxy, target_enable_update, torpedo_write_xy,
         torpedo_write_dxy, torpedo_enable_update, end_of_game, game_won, game_over_w} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: controls not all zero in reset");
    end
    n_cmp++;
    if (score !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_score: got %0d expected 0", score);
    end
    n_cmp++;
    if ({target_write_x, target_write_y, target_write_dx, target_write_dy} !==
        {10'd0, 9'd48, 2'd1, 2'd0}) begin
      n_bad++;
      $display("FAIL target_consts: got x=%0d y=%0d dx=%0d dy=%0d expected 0 48 1 0",
               target_write_x, target_write_y, target_write_dx, target_write_dy);
    end
    n_cmp++;
    if ({torpedo_write_x, torpedo_write_y, torpedo_write_dx, torpedo_write_dy} !==
        {10'd320, 9'd464, 2'd0, 2'd3}) begin
      n_bad++;
      $display("FAIL torpedo_consts: got x=%0d y=%0d dx=%0d dy=%0d expected 320 464 0 3",
               torpedo_write_x, torpedo_write_y, torpedo_write_dx, torpedo_write_dy);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (obs_state() !== S_START) begin
      n_bad++;
      $display("FAIL start_after_reset: state %0d expected %0d", obs_state(), S_START);
    end
    step();
    n_cmp++;
    if (obs_state() !== S_AIM) begin
      n_bad++;
      $display("FAIL aim_after_start: state %0d expected %0d", obs_state(), S_AIM);
    end
  endtask

  task automatic test_hit();
    launch = 1'b1;
    step();
    launch = 1'b0;
    n_cmp++;
    if (obs_state() !== S_SHOOT) begin
      n_bad++;
      $display("FAIL hit_shoot: state %0d expected %0d", obs_state(), S_SHOOT);
    end
    collision = 1'b1;
    step();
    collision = 1'b0;
    n_cmp++;
    if (obs_state() !== S_WON || game_won !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_won: state %0d game_won %0b expected %0d and 1", obs_state(), game_won, S_WON);
    end
    n_cmp++;
    if (score !== 2'd1) begin
      n_bad++;
      $display("FAIL hit_score: got %0d expected 1", score);
    end
    wait_pause(16, S_START, "hit_pause");
    step();
  endtask

  task automatic test_miss();
    launch = 1'b1;
    step();
    launch = 1'b0;
    torpedo_hit_wall = 1'b1;
    step();
    torpedo_hit_wall = 1'b0;
    n_cmp++;
    if (obs_state() !== S_LOST || game_won !== 1'b0) begin
      n_bad++;
      $display("FAIL miss_lost: state %0d game_won %0b expected %0d and 0", obs_state(), game_won, S_LOST);
    end
    n_cmp++;
    if (score !== 2'd1) begin
      n_bad++;
      $display("FAIL miss_score: got %0d expected 1", score);
    end
    wait_pause(16, S_START, "miss_pause");
    step();
  endtask

  task automatic test_priority();
    launch = 1'b1;
    step();
    launch = 1'b0;
    collision = 1'b1;
    target_hit_wall = 1'b1;
    step();
    collision = 1'b0;
    target_hit_wall = 1'b0;
    n_cmp++;
    if (obs_state() !== S_WON || score !== 2'd2) begin
      n_bad++;
      $display("FAIL collision_priority: state %0d score %0d expected %0d and 2", obs_state(), score, S_WON);
    end
    wait_pause(16, S_START, "priority_pause");
    step();
    target_hit_wall = 1'b1;
    launch = 1'b1;
    step();
    target_hit_wall = 1'b0;
    launch = 1'b0;
    n_cmp++;
    if (obs_state() !== S_LOST) begin
      n_bad++;
      $display("FAIL wall_over_launch: state %0d expected %0d", obs_state(), S_LOST);
    end
  endtask

  // Entered in LOST at timer 15: three live cycles, ten frozen, then thirteen more to START.
  task automatic test_gating();
    launch = 1'b1;
    collision = 1'b1;
    repeat (3) step();
    launch = 1'b0;
    collision = 1'b0;
    n_cmp++;
    if (obs_state() !== S_LOST) begin
      n_bad++;
      $display("FAIL pause_ignores_inputs: state %0d expected %0d", obs_state(), S_LOST);
    end
    enable = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (obs_state() !== S_LOST) begin
      n_bad++;
      $display("FAIL gated_hold: state %0d expected %0d", obs_state(), S_LOST);
    end
    enable = 1'b1;
    wait_pause(13, S_START, "gated_timer_resume");
    launch = 1'b1;
    step();
    n_cmp++;
    if (obs_state() !== S_AIM) begin
      n_bad++;
      $display("FAIL held_launch_start: state %0d expected %0d", obs_state(), S_AIM);
    end
    enable = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (obs_state() !== S_AIM) begin
      n_bad++;
      $display("FAIL gated_aim: state %0d expected %0d", obs_state(), S_AIM);
    end
    enable = 1'b1;
    step();
    launch = 1'b0;
    n_cmp++;
    if (obs_state() !== S_SHOOT) begin
      n_bad++;
      $display("FAIL held_launch_accept: state %0d expected %0d", obs_state(), S_SHOOT);
    end
  endtask

  // Starts in SHOOT with score 2; wins three, five wins in total.
  task automatic test_saturation();
    logic [1:0] exp_score [3];
    exp_score = '{2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin
        launch = 1'b1;
        step();
        launch = 1'b0;
      end
      collision = 1'b1;
      step();
      collision = 1'b0;
      n_cmp++;
      if (obs_state() !== S_WON || score !== exp_score[k]) begin
        n_bad++;
        $display("FAIL saturation_%0d: state %0d score %0d expected %0d and %0d",
                 k, obs_state(), score, S_WON, exp_score[k]);
      end
      wait_pause(16, S_START, "saturation_pause");
      step();
    end
  endtask

  task automatic test_async_reset();
    launch = 1'b1;
    step();
    launch = 1'b0;
    n_cmp++;
    if (obs_state() !== S_SHOOT) begin
      n_bad++;
      $display("FAIL pre_reset_shoot: state %0d expected %0d", obs_state(), S_SHOOT);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_state() !== S_INIT || score !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset: state %0d score %0d expected %0d and 0", obs_state(), score, S_INIT);
    end
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (obs_state() !== S_START) begin
      n_bad++;
      $display("FAIL restart_after_reset: state %0d expected %0d", obs_state(), S_START);
    end
    step();
  endtask

`ifdef GAME_ROUND_FSM_LIVES_EN
  task automatic test_lives();
    for (int k = 0; k < 3; k++) begin
      target_hit_wall = 1'b1;
      step();
      target_hit_wall = 1'b0;
      n_cmp++;
      if (obs_state() !== S_LOST) begin
        n_bad++;
        $display("FAIL lives_loss_%0d: state %0d expected %0d", k, obs_state(), S_LOST);
      end
      if (k < 2) begin
        wait_pause(16, S_START, "lives_pause");
        step();
      end else begin
        wait_pause(16, S_OVER, "lives_over");
      end
    end
    launch = 1'b1;
    repeat (5) step();
    launch = 1'b0;
    n_cmp++;
    if (obs_state() !== S_OVER || game_over_w !== 1'b1) begin
      n_bad++;
      $display("FAIL over_hold: state %0d game_over %0b expected %0d and 1", obs_state(), game_over_w, S_OVER);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (game_over_w !== 1'b0 || obs_state() !== S_INIT) begin
      n_bad++;
      $display("FAIL over_reset: state %0d game_over %0b expected %0d and 0", obs_state(), game_over_w, S_INIT);
    end
    step();
    rst = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_priority();
    test_gating();
    test_saturation();
    test_async_reset();
`ifdef GAME_ROUND_FSM_LIVES_EN
    test_lives();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
